// File: rtl/button_reader.sv
// Push-button front end: 2-flop sync, debounce FSM, registered press/release/long strobes and press count.
// Latency DEBOUNCE_CYCLES+2 from the first edge sampling a stable pin to PRESS/RELEASE; no backpressure, strobes are one-shot.
// Optional BUTTON_READER_LONG_PRESS_EN adds the saturating hold counter and LONG strobe; otherwise LONG is tied low.
module button_reader #(
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int LONG_CYCLES     = 48000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN,
    output logic       LEVEL,
    output logic       PRESS,
    output logic       RELEASE,
    output logic       LONG,
    output logic [7:0] PRESS_CNT
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic          raw;
    logic [DW-1:0] db_q, db_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic [7:0]    cnt_q, cnt_d;

    // Both sync flops reset to the idle pin level so reset never looks like a press.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
        end else begin
            sync1_q <= BTN;
            sync2_q <= sync1_q;
        end
    end

    assign raw = sync2_q ^ ACTIVE_LOW;

    always_comb begin
        state_d   = state_q;
        db_d      = db_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (raw) begin
                    state_d = PRESS_WAIT;
                    db_d    = '0;
                end
            end
            PRESS_WAIT: begin
                if (!raw) begin
                    state_d = IDLE;
                end else if (db_q == DB_LAST) begin
                    state_d = HELD;
                    press_d = 1'b1;
                    level_d = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                end else begin
                    db_d = db_q + DW'(1);
                end
            end
            HELD: begin
                if (!raw) begin
                    state_d = RELEASE_WAIT;
                    db_d    = '0;
                end
            end
            RELEASE_WAIT: begin
                if (raw) begin
                    state_d = HELD;
                end else if (db_q == DB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    db_d = db_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            db_q      <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            db_q      <= db_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef BUTTON_READER_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    // Saturating at LONG_CYCLES means HOLD_LAST is passed only once per press,
    // even across release bounces where the count is frozen and later resumes.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (press_d) begin
            hold_d = '0;
        end else if (state_q == HELD) begin
            if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + HW'(1);
            end
            if (hold_q == HOLD_LAST) begin
                long_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign LONG = long_q;
`else
    assign LONG = 1'b0;
`endif

    assign LEVEL     = level_q;
    assign PRESS     = press_q;
    assign RELEASE   = release_q;
    assign PRESS_CNT = cnt_q;

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1.
module tb_button_reader;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       BTN = 1'b1;
    logic       LEVEL, PRESS, RELEASE, LONG;
    logic [7:0] PRESS_CNT;

`ifdef BUTTON_READER_LONG_PRESS_EN
    localparam int LONG_EXP = 1;
`else
    localparam int LONG_EXP = 0;
`endif

    button_reader #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .BTN      (BTN),
        .LEVEL    (LEVEL),
        .PRESS    (PRESS),
        .RELEASE  (RELEASE),
        .LONG     (LONG),
        .PRESS_CNT(PRESS_CNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int press_n = 0, release_n = 0, long_n = 0;
    int last_press = -1, last_release = -1, last_long = -1;
    int excl_viol = 0, wide_viol = 0;
    logic prev_strobe = 1'b0;

    always @(negedge CLK) begin
        if (PRESS) begin
            press_n    <= press_n + 1;
            last_press <= cyc;
        end
        if (RELEASE) begin
            release_n    <= release_n + 1;
            last_release <= cyc;
        end
        if (LONG) begin
            long_n    <= long_n + 1;
            last_long <= cyc;
        end
        if ((int'(PRESS) + int'(RELEASE) + int'(LONG)) > 1) excl_viol <= excl_viol + 1;
        if (prev_strobe && (PRESS || RELEASE || LONG)) wide_viol <= wide_viol + 1;
        prev_strobe <= PRESS | RELEASE | LONG;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    int p0, r0, l0, ts, tr;

    initial begin
        // Reset with pin idle (high).
        RST = 1'b1;
        BTN = 1'b1;
        tick(3);
        chk("rst_level", int'(LEVEL), 0);
        chk("rst_press", int'(PRESS), 0);
        chk("rst_release", int'(RELEASE), 0);
        chk("rst_long", int'(LONG), 0);
        chk("rst_cnt", int'(PRESS_CNT), 0);
        RST = 1'b0;
        tick(4);

        // Bounce reject: 3 low / 3 high, five times.
        p0 = press_n; r0 = release_n; l0 = long_n;
        for (int i = 0; i < 5; i++) begin
            BTN = 1'b0; tick(3);
            BTN = 1'b1; tick(3);
        end
        tick(10);
        chk("bounce_press", press_n - p0, 0);
        chk("bounce_release", release_n - r0, 0);
        chk("bounce_long", long_n - l0, 0);
        chk("bounce_level", int'(LEVEL), 0);
        chk("bounce_cnt", int'(PRESS_CNT), 0);

        // Clean press held 30 cycles, then clean release.
        p0 = press_n; r0 = release_n; l0 = long_n;
        BTN = 1'b0; ts = cyc + 1;
        tick(30);
        chk("clean_press_n", press_n - p0, 1);
        chk("clean_press_at", last_press - ts, 6);
        chk("clean_level", int'(LEVEL), 1);
        chk("clean_cnt", int'(PRESS_CNT), 1);
        chk("clean_long_n", long_n - l0, LONG_EXP);
`ifdef BUTTON_READER_LONG_PRESS_EN
        chk("clean_long_at", last_long - last_press, 20);
`endif
        BTN = 1'b1; tr = cyc + 1;
        tick(12);
        chk("clean_rel_n", release_n - r0, 1);
        chk("clean_rel_at", last_release - tr, 6);
        chk("clean_rel_level", int'(LEVEL), 0);

        // Short press, then release with a bounce; hold stays under 20 cycles.
        p0 = press_n; r0 = release_n; l0 = long_n;
        BTN = 1'b0; tick(8);
        BTN = 1'b1; tick(2);
        BTN = 1'b0; tick(2);
        BTN = 1'b1; tr = cyc + 1;
        tick(10);
        chk("bncrel_press_n", press_n - p0, 1);
        chk("bncrel_rel_n", release_n - r0, 1);
        chk("bncrel_rel_at", last_release - tr, 6);
        chk("bncrel_long_n", long_n - l0, 0);
        chk("bncrel_level", int'(LEVEL), 0);
        chk("bncrel_cnt", int'(PRESS_CNT), 2);

        // Reset 10 cycles into HELD with the button still down.
        BTN = 1'b0; ts = cyc + 1;
        tick(17);
        chk("mid_level_pre", int'(LEVEL), 1);
        p0 = press_n;
        RST = 1'b1; tick(1);
        chk("mid_rst_level", int'(LEVEL), 0);
        chk("mid_rst_press", int'(PRESS), 0);
        chk("mid_rst_cnt", int'(PRESS_CNT), 0);
        RST = 1'b0; ts = cyc + 1;
        tick(10);
        chk("mid_repress_n", press_n - p0, 1);
        chk("mid_repress_at", last_press - ts, 6);
        chk("mid_cnt", int'(PRESS_CNT), 1);
        chk("mid_level", int'(LEVEL), 1);
        BTN = 1'b1; tick(10);

        // Counter wrap from a fresh reset.
        RST = 1'b1; tick(2);
        RST = 1'b0; tick(2);
        p0 = press_n; l0 = long_n;
        for (int i = 0; i < 255; i++) begin
            BTN = 1'b0; tick(8);
            BTN = 1'b1; tick(8);
        end
        chk("wrap_cnt_255", int'(PRESS_CNT), 255);
        BTN = 1'b0; tick(8);
        BTN = 1'b1; tick(8);
        chk("wrap_cnt_0", int'(PRESS_CNT), 0);
        chk("wrap_press_n", press_n - p0, 256);
        chk("wrap_long_n", long_n - l0, 0);

        // Long hold of 50 cycles: LONG only with the feature built in.
        p0 = press_n; r0 = release_n; l0 = long_n;
        BTN = 1'b0; ts = cyc + 1;
        tick(50);
        chk("hold50_press_at", last_press - ts, 6);
        chk("hold50_long_n", long_n - l0, LONG_EXP);
`ifdef BUTTON_READER_LONG_PRESS_EN
        chk("hold50_long_at", last_long - last_press, 20);
`endif
        BTN = 1'b1; tr = cyc + 1;
        tick(10);
        chk("hold50_rel_at", last_release - tr, 6);
        chk("hold50_rel_n", release_n - r0, 1);
        chk("hold50_cnt", int'(PRESS_CNT), 1);

        chk("strobe_exclusive", excl_viol, 0);
        chk("strobe_one_cycle", wide_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
